// File: rtl/video_fetcher.sv
// Video fetch responder: turns generator addresses into DRAM reads and
// buffers returned words in a credit-limited first-word-fall-through FIFO.
module video_fetcher #(
  parameter int FIFO_LOG2 = 3,
  parameter int MAX_OUT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic [20:0] video_addr,
  output logic        video_next,
  output logic        dram_req,
  output logic [20:0] dram_addr,
  input  logic        dram_ack,
  input  logic        dram_rvalid,
  input  logic [15:0] dram_rdata,
  input  logic        pix_rd,
  output logic [15:0] pix_data,
  output logic        pix_empty
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int OW    = $clog2(MAX_OUT + 1);
  localparam int CW    = FIFO_LOG2 + 1;
  localparam int PW    = FIFO_LOG2;
  localparam int SW    = FIFO_LOG2 + 2;

  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);
  localparam logic [OW:0]   MAXO_W  = (OW + 1)'(MAX_OUT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [15:0]   mem_q [DEPTH];

  logic          ack;
  logic          rv_drop;
  logic          rv_take;
  logic          wr;
  logic          rd;
  logic          can_req;
  logic          can_post;
  logic [SW-1:0] used;
  logic [SW-1:0] used_post;
  logic [OW:0]   out_post;

  assign dram_req   = (state_q == REQ);
  assign dram_addr  = video_addr;
  assign ack        = dram_req & dram_ack;
  assign video_next = ack;

  assign pix_empty = (cnt_q == '0);
  assign pix_data  = pix_empty ? '0 : mem_q[rptr_q];

  // Credits cover both buffered words and reads still in flight.
  assign used      = SW'(cnt_q) + SW'(out_q);
  assign used_post = used + SW'(1);
  assign out_post  = {1'b0, out_q} + (OW + 1)'(1);

  assign can_req  = fetch_en & ~flush
                  & (used < DEPTH_W)
                  & ({1'b0, out_q} < MAXO_W);
  assign can_post = fetch_en & ~flush
                  & (used_post < DEPTH_W)
                  & (out_post < MAXO_W);

  // Stale returns from before a flush come back first, in order.
  assign rv_drop = dram_rvalid & (drop_q != '0);
  assign rv_take = dram_rvalid & (drop_q == '0) & (out_q != '0);
  assign wr      = rv_take & ~flush;
  assign rd      = pix_rd & ~pix_empty & ~flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (can_req) state_d = REQ;
      REQ:     if (dram_ack) state_d = can_post ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d  = out_q + OW'(ack) - OW'(rv_take);
    drop_d = drop_q - OW'(rv_drop);
    cnt_d  = cnt_q + CW'(wr) - CW'(rd);
    if (flush) begin
      drop_d = out_q + OW'(ack) - OW'(rv_take);
      out_d  = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr) wptr_q <= wptr_q + PW'(1);
        if (rd) rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= dram_rdata;
  end

endmodule

// File: tb/tb_video_fetcher.sv
// Randomized bench for video_fetcher: arbiter/memory/generator model,
// in-order read tracking with flush epochs, and a FIFO-head scoreboard.
module tb_video_fetcher;

  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        flush;
  logic [20:0] video_addr;
  logic        video_next;
  logic        dram_req;
  logic [20:0] dram_addr;
  logic        dram_ack;
  logic        dram_rvalid;
  logic [15:0] dram_rdata;
  logic        pix_rd;
  logic [15:0] pix_data;
  logic        pix_empty;

  video_fetcher #(.FIFO_LOG2(3), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .flush(flush),
    .video_addr(video_addr), .video_next(video_next),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_ack(dram_ack),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .pix_rd(pix_rd), .pix_data(pix_data), .pix_empty(pix_empty)
  );

  always #18 clk = ~clk;

  typedef struct {
    bit          keep;
    logic [15:0] data;
    int          t;
  } ent_t;

  ent_t        infl[$];
  logic [15:0] expq[$];

  int errors = 0;
  int checks = 0;

  int p_en, p_ack, ack_wait, rv_lat, p_rv, p_rd, p_flush, p_spur;
  int cyc = 0, age = 0, nv = 0;
  bit req_prev, ack_prev, en_prev, fl_prev, rv_prev, mon_en;
  int k_prev, f_prev;
  logic [20:0] va, addr_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic logic [15:0] dat(input logic [20:0] a);
    return a[15:0] ^ {a[20:16], 11'h2A5};
  endfunction

  // Monitor: FIFO head must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() == 0) begin
        chk("pix_empty", pix_empty, 1);
        chk("pix_data_empty", pix_data, 0);
      end else begin
        chk("pix_empty", pix_empty, 0);
        chk("pix_data", pix_data, expq[0]);
        if (pix_rd) void'(expq.pop_front());
      end
    end
  end

  task automatic step();
    ent_t e;
    bit exp_req;
    bit drops;
    int kept;
    @(posedge clk);
    if (rv_prev && infl.size() > 0) begin
      e = infl.pop_front();
      if (e.keep && !fl_prev) expq.push_back(e.data);
    end
    if (ack_prev) begin
      e.keep = 1'b1;
      e.data = dat(addr_prev);
      e.t    = cyc - 1;
      infl.push_back(e);
      va = 21'($urandom);
    end
    if (fl_prev) begin
      foreach (infl[i]) infl[i].keep = 1'b0;
      expq.delete();
    end
    #1;
    if (req_prev && !ack_prev) exp_req = 1'b1;
    else if (req_prev)
      exp_req = en_prev && !fl_prev && (k_prev + 1 < MAX_OUT)
             && (k_prev + 1 + f_prev < DEPTH);
    else
      exp_req = en_prev && !fl_prev && (k_prev < MAX_OUT)
             && (k_prev + f_prev < DEPTH);
    chk("dram_req", dram_req, exp_req);
    kept = 0;
    drops = 1'b0;
    foreach (infl[i]) begin
      if (infl[i].keep) kept++;
      else drops = 1'b1;
    end
    chk("credit", (kept <= MAX_OUT) && (kept + expq.size() <= DEPTH), 1);
    if (dram_req) age = (req_prev && !ack_prev) ? age + 1 : 0;
    fetch_en   = pct(p_en);
    flush      = !drops && pct(p_flush);
    video_addr = va;
    dram_ack   = dram_req && (age >= ack_wait) && pct(p_ack);
    if (infl.size() > 0) begin
      dram_rvalid = (cyc - infl[0].t >= rv_lat) && pct(p_rv);
      dram_rdata  = infl[0].data;
    end else begin
      dram_rvalid = pct(p_spur);
      dram_rdata  = 16'($urandom);
    end
    pix_rd = pct(p_rd);
    #1;
    chk("video_next", video_next, dram_req & dram_ack);
    chk("dram_addr", dram_addr, video_addr);
    if (video_next) nv++;
    req_prev  = dram_req;
    ack_prev  = dram_req && dram_ack;
    en_prev   = fetch_en;
    fl_prev   = flush;
    rv_prev   = dram_rvalid;
    k_prev    = kept;
    f_prev    = expq.size();
    addr_prev = video_addr;
    cyc++;
  endtask

  task automatic knobs(input int en, input int ak, input int aw,
                       input int rl, input int rv, input int rp,
                       input int fl, input int sp);
    p_en = en; p_ack = ak; ack_wait = aw; rv_lat = rl;
    p_rv = rv; p_rd = rp; p_flush = fl; p_spur = sp;
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 0; flush = 0; dram_ack = 0; dram_rvalid = 0;
    dram_rdata = '0; pix_rd = 0;
    va = 21'h01234;
    video_addr = va;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dram_req", dram_req, 0);
    chk("rst_video_next", video_next, 0);
    chk("rst_pix_empty", pix_empty, 1);
    chk("rst_pix_data", pix_data, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Fill: ack every cycle, returns two cycles later, no pops.
    knobs(100, 100, 0, 2, 100, 0, 0, 0);
    nv = 0;
    repeat (40) step();
    chk("fill_video_next_cnt", nv, 8);
    chk("fill_req_idle", dram_req, 0);
    chk("fill_fifo_full", pix_empty, 0);
    knobs(0, 100, 0, 2, 100, 100, 0, 0);
    repeat (12) step();
    chk("drain_empty", pix_empty, 1);

    // Late ack while the fetch window closes.
    knobs(100, 100, 5, 2, 100, 100, 0, 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) p_en = 0;
      step();
    end
    chk("late_ack_next_cnt", nv, 1);

    // No returns: requests stop at the outstanding limit.
    knobs(100, 100, 0, 0, 0, 0, 0, 0);
    nv = 0;
    repeat (10) step();
    chk("maxout_next_cnt", nv, 2);
    chk("maxout_req_low", dram_req, 0);
    knobs(0, 100, 0, 0, 100, 100, 0, 0);
    repeat (12) step();

    // Spurious returns with nothing outstanding.
    knobs(0, 100, 0, 0, 0, 100, 0, 100);
    repeat (6) step();
    chk("spurious_empty", pix_empty, 1);

    // Randomized traffic, flushes and pops.
    for (int r = 0; r < 20; r++) begin
      knobs($urandom_range(100), $urandom_range(100, 20),
            $urandom_range(3), $urandom_range(4),
            $urandom_range(100, 30), $urandom_range(100),
            $urandom_range(5), $urandom_range(20));
      repeat (200) step();
    end

    knobs(0, 100, 0, 0, 100, 100, 0, 0);
    repeat (20) step();
    chk("final_empty", pix_empty, 1);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_fetcher.md
# video_fetcher

Responder side of the video fetch handshake. Takes the 21-bit word address presented by the video address generator, issues it to the DRAM arbiter as a read cycle, and pulses `video_next` once the arbiter accepts it so the generator advances. Returned 16-bit words are queued in a small first-word-fall-through FIFO for the pixel renderer. Outstanding reads are credit-limited so the FIFO never overflows.

## Interface
Parameters:
- `FIFO_LOG2`, 3: FIFO depth is 2^FIFO_LOG2 words (8).
- `MAX_OUT`, 2: maximum DRAM reads accepted but not yet returned.

Ports:
- `clk`  in  1  28 MHz system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  fetch window (vpix region); new requests only while high.
- `flush`  in  1  one-cycle pulse; empties the FIFO and discards in-flight returns.
- `video_addr`  in  21  word address from the generator; valid whenever `dram_req` is high.
- `video_next`  out  1  one-cycle strobe; the generator advances its address.
- `dram_req`  out  1  read request to the arbiter.
- `dram_addr`  out  21  equals `video_addr`.
- `dram_ack`  in  1  arbiter accepts the request this cycle.
- `dram_rvalid`  in  1  read data valid.
- `dram_rdata`  in  16  read data.
- `pix_rd`  in  1  renderer pops the head word.
- `pix_data`  out  16  FIFO head; forced to 0 while `pix_empty`.
- `pix_empty`  out  1  FIFO empty.

## Operation
- FSM states: IDLE, REQ. `dram_req` = (state == REQ).
- Credit check: `can_req` = fetch_en & ~flush & (fifo_cnt + outstanding < 2^FIFO_LOG2) & (outstanding < MAX_OUT).
- IDLE -> REQ when `can_req`.
- In REQ, `dram_req` is held until `dram_ack`. It is never withdrawn, even if `fetch_en` falls or `flush` pulses.
- On `dram_req & dram_ack`:
  - `video_next` = 1 in the same cycle (combinational AND).
  - `outstanding` increments.
  - Next state is REQ if `can_req` still holds after the increment is counted; otherwise IDLE.
  - The generator loads its new address at that edge, so back-to-back requests present a fresh address.
- Return path, on `dram_rvalid`:
  - If `drop_cnt` > 0: decrement `drop_cnt` and do not write the FIFO.
  - Else if `outstanding` > 0: write `dram_rdata` into the FIFO and decrement `outstanding`.
  - Else (protocol error): ignore the word.
- `flush`:
  - FIFO pointers and count go to 0.
  - `drop_cnt` <= `outstanding` + (ack this cycle); `outstanding` <= 0.
  - A `dram_rvalid` in the flush cycle is dropped and counted against the old `outstanding`.
  - A pending request acked after the flush is a new-epoch read: its data is kept.
- FIFO: `pix_rd` while empty is ignored. A simultaneous write and read leaves the count unchanged. Overflow is impossible by construction.
- Widths:
  - `fifo_cnt`: FIFO_LOG2+1 bits.
  - `outstanding`, `drop_cnt`: clog2(MAX_OUT+1) bits.
  - Pointers: FIFO_LOG2 bits, natural wrap.

## Timing
- Reset values: state IDLE, `dram_req` 0, `video_next` 0, `pix_empty` 1, `pix_data` 0. FIFO and all counters are 0.
- Request latency: `fetch_en` rises at cycle N (credits available), so `dram_req` = 1 at N+1.
- Ack handling: ack at cycle M gives `video_next` at M. The next `dram_req` at M+1 carries the new address.
- Data latency: `dram_rvalid` at cycle R gives `pix_empty` = 0 and valid `pix_data` at R+1.
- Pop: `pix_rd` at cycle P shows the next head, or empty, at P+1.
- Peak throughput: one request per cycle while credits allow.
- `rst` overrides all inputs, including an in-progress REQ and `flush`.

## Test plan
- Reset then `fetch_en`=1, arbiter acks every cycle, rvalid 2 cycles after ack, no pops -> exactly 8 `video_next` pulses; `dram_req` stays 0 afterwards; the FIFO holds 8 words in address order.
- Delay the ack 5 cycles while `fetch_en` drops at cycle 2 -> `dram_req` stays high to the ack; 1 `video_next`; no further requests.
- With no rvalid returned: request 2 reads -> `dram_req` falls at `outstanding`=2 (MAX_OUT); the first rvalid re-enables requests the next cycle.
- `flush` with 2 outstanding and 3 words in the FIFO -> `pix_empty`=1 the next cycle; the next 2 rvalids are dropped; the 3rd rvalid (0xBEEF, acked after the flush) appears on `pix_data`.
- `pix_rd` held high with the FIFO count at 1 and a simultaneous rvalid -> the count stays 1; the new word becomes head; `pix_rd` on empty causes no underflow.
- Spurious `dram_rvalid` with `outstanding`=0 -> FIFO unchanged, `pix_empty` stays 1.
